// File: rtl/reservation_station_if.sv
// Rename/writeback/execute-facing bundle for the reservation station.
// RS_OCCUPANCY_EN adds occupancy and almost_full.
interface reservation_station_if #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PREG_W  = 6,
  parameter int unsigned INSTR_W = 32
);
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic               disp_valid;
  logic               disp_ready;
  logic [6:0]         disp_opcode;
  logic [PREG_W-1:0]  disp_ps1;
  logic [PREG_W-1:0]  disp_ps2;
  logic [PREG_W-1:0]  disp_pd;
  logic               disp_ps1_rdy;
  logic               disp_ps2_rdy;
  logic [INSTR_W-1:0] disp_instr;
  logic               wb_valid;
  logic [PREG_W-1:0]  wb_tag;
  logic               issue_valid;
  logic               issue_ready;
  logic [6:0]         issue_opcode;
  logic [PREG_W-1:0]  issue_ps1;
  logic [PREG_W-1:0]  issue_ps2;
  logic [PREG_W-1:0]  issue_pd;
  logic [INSTR_W-1:0] issue_instr;
  logic               flush;
`ifdef RS_OCCUPANCY_EN
  logic [OCC_W-1:0]   occupancy;
  logic               almost_full;

  modport master (
    output disp_valid, disp_opcode, disp_ps1, disp_ps2, disp_pd, disp_ps1_rdy,
           disp_ps2_rdy, disp_instr, wb_valid, wb_tag, issue_ready, flush,
    input  disp_ready, issue_valid, issue_opcode, issue_ps1, issue_ps2, issue_pd,
           issue_instr, occupancy, almost_full
  );
  modport slave (
    input  disp_valid, disp_opcode, disp_ps1, disp_ps2, disp_pd, disp_ps1_rdy,
           disp_ps2_rdy, disp_instr, wb_valid, wb_tag, issue_ready, flush,
    output disp_ready, issue_valid, issue_opcode, issue_ps1, issue_ps2, issue_pd,
           issue_instr, occupancy, almost_full
  );
`else
  modport master (
    output disp_valid, disp_opcode, disp_ps1, disp_ps2, disp_pd, disp_ps1_rdy,
           disp_ps2_rdy, disp_instr, wb_valid, wb_tag, issue_ready, flush,
    input  disp_ready, issue_valid, issue_opcode, issue_ps1, issue_ps2, issue_pd,
           issue_instr
  );
  modport slave (
    input  disp_valid, disp_opcode, disp_ps1, disp_ps2, disp_pd, disp_ps1_rdy,
           disp_ps2_rdy, disp_instr, wb_valid, wb_tag, issue_ready, flush,
    output disp_ready, issue_valid, issue_opcode, issue_ps1, issue_ps2, issue_pd,
           issue_instr
  );
`endif
endinterface

// File: rtl/reservation_station.sv
// Unified issue queue: holds renamed micro-ops until both sources wake, issues oldest ready.
// Optional RS_OCCUPANCY_EN exposes registered occupancy and almost_full.
module reservation_station #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PREG_W  = 6,
  parameter int unsigned INSTR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reservation_station_if.slave  rs
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = IDX_W + 1;

  typedef struct packed {
    logic [6:0]         opcode;
    logic [PREG_W-1:0]  ps1;
    logic [PREG_W-1:0]  ps2;
    logic [PREG_W-1:0]  pd;
    logic [INSTR_W-1:0] instr;
  } uop_t;

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] rdy1_q;
  logic [DEPTH-1:0] rdy2_q;
  uop_t             payload_q [DEPTH];
  // older_q[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0] older_q [DEPTH];

  logic             full_c;
  logic [IDX_W-1:0] free_idx_c;
  logic             disp_fire_c;
  logic             disp_rdy1_c;
  logic             disp_rdy2_c;
  logic [DEPTH-1:0] cand_c;
  logic [DEPTH-1:0] sel_c;
  logic             blocked_c;
  logic             issue_valid_c;
  logic             issue_fire_c;
  uop_t             issue_pay_c;
  uop_t             disp_pay_c;

  // Lowest-index free slot
  always_comb begin
    free_idx_c = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx_c = IDX_W'(i);
    end
  end

  assign full_c      = &valid_q;
  assign disp_fire_c = rs.disp_valid & ~full_c & ~rs.flush;
  assign disp_rdy1_c = rs.disp_ps1_rdy | (rs.wb_valid && (rs.wb_tag == rs.disp_ps1));
  assign disp_rdy2_c = rs.disp_ps2_rdy | (rs.wb_valid && (rs.wb_tag == rs.disp_ps2));
  assign disp_pay_c  = '{opcode: rs.disp_opcode, ps1: rs.disp_ps1, ps2: rs.disp_ps2,
                         pd: rs.disp_pd, instr: rs.disp_instr};

  // Oldest-ready select: a candidate wins when no other candidate is older
  always_comb begin
    cand_c    = valid_q & rdy1_q & rdy2_q;
    sel_c     = '0;
    blocked_c = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      blocked_c = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        blocked_c = blocked_c | (cand_c[j] & older_q[j][i]);
      end
      sel_c[i] = cand_c[i] & ~blocked_c;
    end
  end

  always_comb begin
    issue_pay_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_c[i]) issue_pay_c = issue_pay_c | payload_q[i];
    end
  end

  assign issue_valid_c = (|cand_c) & ~rs.flush;
  assign issue_fire_c  = issue_valid_c & rs.issue_ready;

  assign rs.disp_ready   = ~full_c;
  assign rs.issue_valid  = issue_valid_c;
  assign rs.issue_opcode = issue_pay_c.opcode;
  assign rs.issue_ps1    = issue_pay_c.ps1;
  assign rs.issue_ps2    = issue_pay_c.ps2;
  assign rs.issue_pd     = issue_pay_c.pd;
  assign rs.issue_instr  = issue_pay_c.instr;

  // Entry state: flush outranks dispatch, issue and wakeup
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        payload_q[i] <= '0;
        older_q[i]   <= '0;
      end
    end else if (rs.flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && rs.wb_valid) begin
          if (payload_q[i].ps1 == rs.wb_tag) rdy1_q[i] <= 1'b1;
          if (payload_q[i].ps2 == rs.wb_tag) rdy2_q[i] <= 1'b1;
        end
        if (issue_fire_c && sel_c[i]) valid_q[i] <= 1'b0;
        if (disp_fire_c && (IDX_W'(i) == free_idx_c)) begin
          valid_q[i]   <= 1'b1;
          rdy1_q[i]    <= disp_rdy1_c;
          rdy2_q[i]    <= disp_rdy2_c;
          payload_q[i] <= disp_pay_c;
          older_q[i]   <= '0;
        end
        if (disp_fire_c && (IDX_W'(i) != free_idx_c)) begin
          older_q[i][free_idx_c] <= valid_q[i];
        end
      end
    end
  end

`ifdef RS_OCCUPANCY_EN
  logic [OCC_W-1:0] occ_q;
  logic             almost_full_q;
  logic [OCC_W-1:0] occ_next_c;

  always_comb begin
    occ_next_c = occ_q + OCC_W'(disp_fire_c) - OCC_W'(issue_fire_c);
    if (rs.flush) occ_next_c = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q         <= '0;
      almost_full_q <= 1'b0;
    end else begin
      occ_q         <= occ_next_c;
      almost_full_q <= (occ_next_c >= OCC_W'(DEPTH - 2));
    end
  end

  assign rs.occupancy   = occ_q;
  assign rs.almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: dispatch, wakeup, oldest-first select, full, flush, hold.
module tb_reservation_station;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned PREG_W  = 6;
  localparam int unsigned INSTR_W = 32;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  reservation_station_if #(.DEPTH(DEPTH), .PREG_W(PREG_W), .INSTR_W(INSTR_W)) rs_if ();

  reservation_station #(.DEPTH(DEPTH), .PREG_W(PREG_W), .INSTR_W(INSTR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rs    (rs_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_if.disp_valid   = 1'b0;
    rs_if.disp_opcode  = '0;
    rs_if.disp_ps1     = '0;
    rs_if.disp_ps2     = '0;
    rs_if.disp_pd      = '0;
    rs_if.disp_ps1_rdy = 1'b0;
    rs_if.disp_ps2_rdy = 1'b0;
    rs_if.disp_instr   = '0;
    rs_if.wb_valid     = 1'b0;
    rs_if.wb_tag       = '0;
    rs_if.issue_ready  = 1'b0;
    rs_if.flush        = 1'b0;
  endtask

  task automatic disp(input logic [6:0] op, input logic [5:0] ps1, input logic r1,
                      input logic [5:0] ps2, input logic r2, input logic [5:0] pd,
                      input logic [31:0] instr);
    rs_if.disp_valid   = 1'b1;
    rs_if.disp_opcode  = op;
    rs_if.disp_ps1     = ps1;
    rs_if.disp_ps1_rdy = r1;
    rs_if.disp_ps2     = ps2;
    rs_if.disp_ps2_rdy = r2;
    rs_if.disp_pd      = pd;
    rs_if.disp_instr   = instr;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    total_cnt++; if (rs_if.disp_ready !== 1'b1) $display("FAIL reset_disp_ready: got %b exp 1", rs_if.disp_ready); else pass_cnt++;
    total_cnt++; if (rs_if.issue_valid !== 1'b0) $display("FAIL reset_issue_valid: got %b exp 0", rs_if.issue_valid); else pass_cnt++;
    total_cnt++; if (rs_if.issue_pd !== 6'd0 || rs_if.issue_instr !== 32'd0) $display("FAIL reset_payload: got pd %0d instr %h exp 0", rs_if.issue_pd, rs_if.issue_instr); else pass_cnt++;
`ifdef RS_OCCUPANCY_EN
    total_cnt++; if (rs_if.occupancy !== 5'd0 || rs_if.almost_full !== 1'b0) $display("FAIL reset_occ: got %0d/%b exp 0/0", rs_if.occupancy, rs_if.almost_full); else pass_cnt++;
`endif
  endtask

  task automatic test_basic();
    idle();
    rs_if.issue_ready = 1'b1;
    disp(7'h33, 6'd5, 1'b1, 6'd7, 1'b1, 6'd12, 32'hDEADBEEF);
    #1;
    total_cnt++; if (rs_if.issue_valid !== 1'b0) $display("FAIL basic_same_cycle: got %b exp 0", rs_if.issue_valid); else pass_cnt++;
    tick();
    rs_if.disp_valid = 1'b0;
    #1;
    total_cnt++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_pd !== 6'd12) $display("FAIL basic_issue: got v%b pd %0d exp v1 pd 12", rs_if.issue_valid, rs_if.issue_pd); else pass_cnt++;
    total_cnt++; if (rs_if.issue_opcode !== 7'h33 || rs_if.issue_ps1 !== 6'd5 || rs_if.issue_ps2 !== 6'd7 || rs_if.issue_instr !== 32'hDEADBEEF)
      $display("FAIL basic_payload: got op %h ps1 %0d ps2 %0d instr %h exp 33 5 7 deadbeef", rs_if.issue_opcode, rs_if.issue_ps1, rs_if.issue_ps2, rs_if.issue_instr); else pass_cnt++;
    tick();
    total_cnt++; if (rs_if.issue_valid !== 1'b0 || rs_if.disp_ready !== 1'b1) $display("FAIL basic_empty: got v%b rdy%b exp v0 rdy1", rs_if.issue_valid, rs_if.disp_ready); else pass_cnt++;
  endtask

  task automatic test_wakeup();
    idle();
    rs_if.issue_ready = 1'b1;
    disp(7'h13, 6'd9, 1'b0, 6'd3, 1'b1, 6'd20, 32'h1);
    tick();
    disp(7'h13, 6'd4, 1'b1, 6'd3, 1'b1, 6'd21, 32'h2);
    #1;
    total_cnt++; if (rs_if.issue_valid !== 1'b0) $display("FAIL wake_a_blocked: got %b exp 0", rs_if.issue_valid); else pass_cnt++;
    tick();
    rs_if.disp_valid = 1'b0;
    rs_if.wb_valid   = 1'b1;
    rs_if.wb_tag     = 6'd9;
    #1;
    total_cnt++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_pd !== 6'd21) $display("FAIL wake_b_first: got v%b pd %0d exp v1 pd 21", rs_if.issue_valid, rs_if.issue_pd); else pass_cnt++;
    tick();
    rs_if.wb_valid = 1'b0;
    #1;
    total_cnt++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_pd !== 6'd20) $display("FAIL wake_a_after: got v%b pd %0d exp v1 pd 20", rs_if.issue_valid, rs_if.issue_pd); else pass_cnt++;
    tick();
    total_cnt++; if (rs_if.issue_valid !== 1'b0) $display("FAIL wake_empty: got %b exp 0", rs_if.issue_valid); else pass_cnt++;
    // Both sources waiting on the same tag
    disp(7'h33, 6'd22, 1'b0, 6'd22, 1'b0, 6'd31, 32'h3);
    tick();
    rs_if.disp_valid = 1'b0;
    rs_if.wb_valid   = 1'b1;
    rs_if.wb_tag     = 6'd22;
    #1;
    total_cnt++; if (rs_if.issue_valid !== 1'b0) $display("FAIL wake_same_tag_early: got %b exp 0", rs_if.issue_valid); else pass_cnt++;
    tick();
    rs_if.wb_valid = 1'b0;
    #1;
    total_cnt++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_pd !== 6'd31) $display("FAIL wake_same_tag: got v%b pd %0d exp v1 pd 31", rs_if.issue_valid, rs_if.issue_pd); else pass_cnt++;
    tick();
  endtask

  task automatic test_dispatch_wakeup();
    idle();
    rs_if.issue_ready = 1'b1;
    disp(7'h03, 6'd14, 1'b0, 6'd2, 1'b1, 6'd30, 32'h4);
    rs_if.wb_valid = 1'b1;
    rs_if.wb_tag   = 6'd14;
    tick();
    idle();
    rs_if.issue_ready = 1'b1;
    #1;
    total_cnt++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_pd !== 6'd30) $display("FAIL disp_wake: got v%b pd %0d exp v1 pd 30", rs_if.issue_valid, rs_if.issue_pd); else pass_cnt++;
    tick();
  endtask

  task automatic test_full();
    idle();
    for (int i = 0; i < 16; i++) begin
      disp(7'h33, 6'(32 + i), 1'b0, 6'd0, 1'b1, 6'(i), 32'(i));
      if (i == 15) begin
        #1;
        total_cnt++; if (rs_if.disp_ready !== 1'b1) $display("FAIL full_before_last: got %b exp 1", rs_if.disp_ready); else pass_cnt++;
      end
      tick();
    end
    disp(7'h33, 6'd1, 1'b1, 6'd1, 1'b1, 6'd63, 32'h63);
    #1;
    total_cnt++; if (rs_if.disp_ready !== 1'b0 || rs_if.issue_valid !== 1'b0) $display("FAIL full_ready: got rdy%b v%b exp rdy0 v0", rs_if.disp_ready, rs_if.issue_valid); else pass_cnt++;
`ifdef RS_OCCUPANCY_EN
    total_cnt++; if (rs_if.occupancy !== 5'd16 || rs_if.almost_full !== 1'b1) $display("FAIL full_occ: got %0d/%b exp 16/1", rs_if.occupancy, rs_if.almost_full); else pass_cnt++;
`endif
    rs_if.wb_valid    = 1'b1;
    rs_if.wb_tag      = 6'd37;
    rs_if.issue_ready = 1'b1;
    tick();
    rs_if.wb_valid = 1'b0;
    #1;
    total_cnt++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_pd !== 6'd5 || rs_if.disp_ready !== 1'b0)
      $display("FAIL full_issue5: got v%b pd %0d rdy%b exp v1 pd 5 rdy0", rs_if.issue_valid, rs_if.issue_pd, rs_if.disp_ready); else pass_cnt++;
    tick();
    total_cnt++; if (rs_if.disp_ready !== 1'b1 || rs_if.issue_valid !== 1'b0) $display("FAIL full_freed: got rdy%b v%b exp rdy1 v0", rs_if.disp_ready, rs_if.issue_valid); else pass_cnt++;
    // Reused slot 5 is youngest; entry 10 wakes the same cycle and must go first
    disp(7'h33, 6'd1, 1'b1, 6'd1, 1'b1, 6'd50, 32'h50);
    rs_if.wb_valid = 1'b1;
    rs_if.wb_tag   = 6'd42;
    tick();
    rs_if.disp_valid = 1'b0;
    rs_if.wb_valid   = 1'b0;
    #1;
    total_cnt++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_pd !== 6'd10) $display("FAIL full_age_old: got v%b pd %0d exp v1 pd 10", rs_if.issue_valid, rs_if.issue_pd); else pass_cnt++;
    tick();
    total_cnt++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_pd !== 6'd50) $display("FAIL full_age_young: got v%b pd %0d exp v1 pd 50", rs_if.issue_valid, rs_if.issue_pd); else pass_cnt++;
    tick();
    total_cnt++; if (rs_if.issue_valid !== 1'b0) $display("FAIL full_drain: got %b exp 0", rs_if.issue_valid); else pass_cnt++;
`ifdef RS_OCCUPANCY_EN
    total_cnt++; if (rs_if.occupancy !== 5'd14) $display("FAIL full_occ14: got %0d exp 14", rs_if.occupancy); else pass_cnt++;
`endif
    rs_if.flush = 1'b1;
    tick();
    rs_if.flush = 1'b0;
  endtask

  task automatic test_flush();
    idle();
    disp(7'h33, 6'd1, 1'b1, 6'd1, 1'b1, 6'd1, 32'h11); tick();
    disp(7'h33, 6'd60, 1'b0, 6'd1, 1'b1, 6'd2, 32'h12); tick();
    disp(7'h33, 6'd1, 1'b1, 6'd1, 1'b1, 6'd3, 32'h13); tick();
    disp(7'h33, 6'd61, 1'b0, 6'd1, 1'b1, 6'd4, 32'h14); tick();
    disp(7'h33, 6'd1, 1'b1, 6'd1, 1'b1, 6'd5, 32'h15); tick();
    rs_if.disp_valid = 1'b0;
    #1;
    total_cnt++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_pd !== 6'd1) $display("FAIL flush_pre: got v%b pd %0d exp v1 pd 1", rs_if.issue_valid, rs_if.issue_pd); else pass_cnt++;
`ifdef RS_OCCUPANCY_EN
    total_cnt++; if (rs_if.occupancy !== 5'd5 || rs_if.almost_full !== 1'b0) $display("FAIL flush_occ5: got %0d/%b exp 5/0", rs_if.occupancy, rs_if.almost_full); else pass_cnt++;
`endif
    disp(7'h33, 6'd1, 1'b1, 6'd1, 1'b1, 6'd9, 32'h19);
    rs_if.flush       = 1'b1;
    rs_if.issue_ready = 1'b1;
    #1;
    total_cnt++; if (rs_if.issue_valid !== 1'b0) $display("FAIL flush_cycle_valid: got %b exp 0", rs_if.issue_valid); else pass_cnt++;
    tick();
    idle();
    rs_if.issue_ready = 1'b1;
    #1;
    total_cnt++; if (rs_if.issue_valid !== 1'b0 || rs_if.disp_ready !== 1'b1) $display("FAIL flush_after: got v%b rdy%b exp v0 rdy1", rs_if.issue_valid, rs_if.disp_ready); else pass_cnt++;
`ifdef RS_OCCUPANCY_EN
    total_cnt++; if (rs_if.occupancy !== 5'd0) $display("FAIL flush_occ0: got %0d exp 0", rs_if.occupancy); else pass_cnt++;
`endif
    tick();
    total_cnt++; if (rs_if.issue_valid !== 1'b0) $display("FAIL flush_dropped_disp: got %b exp 0", rs_if.issue_valid); else pass_cnt++;
  endtask

  task automatic test_hold();
    idle();
    disp(7'h33, 6'd1, 1'b1, 6'd1, 1'b1, 6'd40, 32'h40); tick();
    disp(7'h33, 6'd1, 1'b1, 6'd1, 1'b1, 6'd41, 32'h41); tick();
    rs_if.disp_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      total_cnt++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_pd !== 6'd40) $display("FAIL hold_c%0d: got v%b pd %0d exp v1 pd 40", c, rs_if.issue_valid, rs_if.issue_pd); else pass_cnt++;
      tick();
    end
`ifdef RS_OCCUPANCY_EN
    total_cnt++; if (rs_if.occupancy !== 5'd2) $display("FAIL hold_occ: got %0d exp 2", rs_if.occupancy); else pass_cnt++;
`endif
    rs_if.issue_ready = 1'b1;
    #1;
    total_cnt++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_pd !== 6'd40) $display("FAIL hold_rel0: got v%b pd %0d exp v1 pd 40", rs_if.issue_valid, rs_if.issue_pd); else pass_cnt++;
    tick();
    total_cnt++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_pd !== 6'd41) $display("FAIL hold_rel1: got v%b pd %0d exp v1 pd 41", rs_if.issue_valid, rs_if.issue_pd); else pass_cnt++;
    tick();
    total_cnt++; if (rs_if.issue_valid !== 1'b0) $display("FAIL hold_empty: got %b exp 0", rs_if.issue_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    idle();
    rs_if.issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      disp(7'h33, 6'd1, 1'b1, 6'd1, 1'b1, 6'(44 + k), 32'(k));
      #1;
      if (k > 0) begin
        total_cnt++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_pd !== 6'(43 + k)) $display("FAIL b2b_%0d: got v%b pd %0d exp v1 pd %0d", k, rs_if.issue_valid, rs_if.issue_pd, 43 + k); else pass_cnt++;
`ifdef RS_OCCUPANCY_EN
        total_cnt++; if (rs_if.occupancy !== 5'd1) $display("FAIL b2b_occ_%0d: got %0d exp 1", k, rs_if.occupancy); else pass_cnt++;
`endif
      end
      tick();
    end
    rs_if.disp_valid = 1'b0;
    tick();
    total_cnt++; if (rs_if.issue_valid !== 1'b0) $display("FAIL b2b_empty: got %b exp 0", rs_if.issue_valid); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    idle();
    disp(7'h33, 6'd1, 1'b1, 6'd1, 1'b1, 6'd55, 32'h55); tick();
    disp(7'h33, 6'd1, 1'b1, 6'd1, 1'b1, 6'd56, 32'h56); tick();
    rs_if.disp_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    total_cnt++; if (rs_if.issue_valid !== 1'b0 || rs_if.disp_ready !== 1'b1 || rs_if.issue_pd !== 6'd0)
      $display("FAIL mid_reset: got v%b rdy%b pd %0d exp v0 rdy1 pd 0", rs_if.issue_valid, rs_if.disp_ready, rs_if.issue_pd); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_wakeup();
    test_dispatch_wakeup();
    test_full();
    test_flush();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Unified issue queue sitting directly downstream of the rename stage.
- Accepts renamed micro-ops (opcode, ps1, ps2, pd, raw instruction) and holds them until both physical sources are ready.
- Wakes sources by matching the writeback broadcast tag.
- Issues the oldest ready entry to the execute stage over a valid/ready handshake.

Parameters:
DEPTH, 16, number of entries; power of two, 4..32
PREG_W, 6, physical register tag width (64 physical registers)
INSTR_W, 32, raw instruction width carried for immediate generation downstream

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
disp_valid  input  1  rename presents a micro-op
disp_ready  output  1  an entry is free this cycle
disp_opcode  input  7  opcode from rename
disp_ps1  input  PREG_W  source-1 physical tag
disp_ps2  input  PREG_W  source-2 physical tag
disp_pd  input  PREG_W  destination physical tag
disp_ps1_rdy  input  1  source-1 value already produced (scoreboard)
disp_ps2_rdy  input  1  source-2 value already produced
disp_instr  input  INSTR_W  raw instruction
wb_valid  input  1  writeback broadcast valid
wb_tag  input  PREG_W  physical tag being written back
issue_valid  output  1  a ready entry is selected
issue_ready  input  1  execute accepts
issue_opcode  output  7  selected entry opcode
issue_ps1  output  PREG_W  selected source-1 tag
issue_ps2  output  PREG_W  selected source-2 tag
issue_pd  output  PREG_W  selected destination tag
issue_instr  output  INSTR_W  selected raw instruction
flush  input  1  discard all entries (mispredict/exception)

Behaviour:
- Reset:
  - All entry valid bits are 0 on the first clk edge with rst_n=0.
  - Age state and payloads are cleared to 0.
  - After reset, disp_ready=1 and issue_valid=0; issue_* payload outputs read 0.
  - Reset asserted mid-operation discards all entries the same way.
- Entry state: valid, rdy1, rdy2, opcode, ps1, ps2, pd, instr, plus an age ordering (age matrix or per-entry sequence number; implementer's choice, results must match oldest-first).
- Dispatch:
  - disp_ready = not full. Registered-state function only; no combinational path from issue_ready.
  - Therefore, when full, a same-cycle issue does not allow a dispatch.
  - On disp_valid && disp_ready, the lowest-index free entry is written at the clk edge and becomes youngest.
- Dispatch-cycle wakeup:
  - Captured rdyN = disp_psN_rdy OR (wb_valid && wb_tag == disp_psN).
  - Prevents a lost wakeup when the producer broadcasts in the dispatch cycle.
- Wakeup:
  - Each cycle, every valid entry with psN == wb_tag while wb_valid=1 sets rdyN at the edge.
  - Both sources may match the same tag.
  - A wakeup becomes visible to select the following cycle.
- Select (combinational from registered state):
  - Candidates are entries with valid && rdy1 && rdy2.
  - issue_valid = any candidate; issue_* reflect the oldest candidate.
- Issue:
  - On issue_valid && issue_ready, the selected entry is invalidated at the edge and its slot is reusable the next cycle.
  - When issue_ready=0, the selection may change if an older entry becomes ready. issue_* stability is not guaranteed without handshake; execute samples only on acceptance.
- Latency: dispatch at cycle N with both sources ready gives issue_valid at the earliest in N+1.
- Simultaneous dispatch + issue: both performed; occupancy unchanged.
- Flush:
  - Takes priority over dispatch, issue and wakeup.
  - In the flush cycle, issue_valid is forced to 0 and a dispatch handshake is dropped.
  - All valid bits clear at the edge.
- Empty: issue_valid=0 and issue_* hold the last driven values (don't-care).
- Full: disp_ready=0; disp_valid is ignored.
- Tag 0 receives no special treatment; rename/scoreboard must present rdy=1 for the architectural zero register.

Optional Feature:
- Macro RS_OCCUPANCY_EN.
- Defined:
  - Adds output occupancy, width $clog2(DEPTH)+1, equal to the number of valid entries (registered, reset 0).
  - Adds output almost_full, 1 bit, high when occupancy >= DEPTH-2.
  - Both update on the same edge as entry state.
  - Flush sets occupancy to 0 next cycle.
- Not defined: neither port exists; all other behaviour is identical.

Test Plan:
- Reset then dispatch opcode 0x33, ps1=5 rdy, ps2=7 rdy, pd=12, issue_ready=1 -> issue_valid=1 next cycle with pd=12; queue empty the cycle after.
- Dispatch A (ps1=9 not ready, pd=20), then B (both ready, pd=21), then wb_valid tag=9 -> B issues first; A issues the cycle after the wakeup edge.
- Dispatch with ps1=14 not ready while wb_valid=1, wb_tag=14 -> entry captured ready and issues next cycle (no lost wakeup).
- Fill 16 entries with sources not ready -> disp_ready=0 on the cycle after the 16th; broadcast one tag and issue -> disp_ready=1 the following cycle; oldest-first order holds across reused slots.
- Occupancy 5 with three ready entries, assert flush with disp_valid=1 -> issue_valid=0 that cycle; next cycle empty, disp_ready=1 and issue_valid=0; occupancy=0 when RS_OCCUPANCY_EN is defined.
- Hold issue_ready=0 for 4 cycles with two ready entries -> no entry removed, issue_valid stays 1 and points to the oldest; release -> entries issue in age order on consecutive cycles.
